// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with glitch-rejecting start detect, parity/framing/overrun flags and a holding register.
// Latency: 2 clk sync + mid-bit sampling, outputs update 1 clk after last stop sample; no backpressure (unread data is overwritten, overrun flagged).
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_sync;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc, perr_acc;
  logic                 sample_end, frame_done, frame_ferr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // sample_end marks the mid-bit tick of each bit after the start bit
  always_comb begin
    sample_end = s_tick && (tick_cnt == TICK_END);
    frame_ferr = ferr_acc || !rx_sync;
    frame_done = 1'b0;
    state_nxt  = state;
    case (state)
      IDLE:     if (!rx_sync) state_nxt = START;
      START:    if (s_tick && (tick_cnt == TICK_MID)) state_nxt = rx_sync ? IDLE : DATA;
      DATA:     if (sample_end && (bit_cnt == BW'(DATA_BITS - 1)))
                  state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:   if (sample_end) state_nxt = STOP;
      STOP:     if (sample_end && (bit_cnt == BW'(STOP_BITS - 1))) begin
                  frame_done = 1'b1;
                  state_nxt  = frame_ferr ? BRK_WAIT : IDLE;
                end
      BRK_WAIT: if (rx_sync) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      ferr_acc <= 1'b0;
      perr_acc <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state)
        tick_cnt <= '0;
      else if (s_tick && (state != IDLE))
        tick_cnt <= (tick_cnt == TICK_END) ? '0 : tick_cnt + 1'b1;

      if (state_nxt != state)
        bit_cnt <= '0;
      else if (sample_end && ((state == DATA) || (state == STOP)))
        bit_cnt <= bit_cnt + 1'b1;

      if ((state == DATA) && sample_end)
        shreg <= {rx_sync, shreg[DATA_BITS-1:1]};

      if (state == IDLE) begin
        ferr_acc <= 1'b0;
        perr_acc <= 1'b0;
      end else if ((state == STOP) && sample_end && !rx_sync) begin
        ferr_acc <= 1'b1;
      end else if ((state == PARITY) && sample_end) begin
        perr_acc <= ((^shreg) ^ rx_sync) != 1'(PARITY_ODD);
      end
    end
  end

  // A completing frame always wins over a same-cycle rd
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else if (frame_done) begin
      rx_data     <= shreg;
      framing_err <= frame_ferr;
      parity_err  <= perr_acc;
      rx_valid    <= 1'b1;
      overrun_err <= rx_valid && !rd;
    end else if (rd && rx_valid) begin
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and an 8E1 instance driven from a shared bit-level line driver.
module tb_uart_rx_param;

  logic clk, reset, s_tick, line, sel, rd_req;
  logic rx_a, rx_b, rd_a, rd_b;
  logic [7:0] data_a, data_b;
  logic valid_a, ferr_a, perr_a, ovr_a, busy_a;
  logic valid_b, ferr_b, perr_b, ovr_b, busy_b;

  assign rx_a = sel ? 1'b1 : line;
  assign rx_b = sel ? line : 1'b1;
  assign rd_a = sel ? 1'b0 : rd_req;
  assign rd_b = sel ? rd_req : 1'b0;

  uart_rx_param dut_a (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_a), .rd(rd_a),
    .rx_data(data_a), .rx_valid(valid_a), .framing_err(ferr_a),
    .parity_err(perr_a), .overrun_err(ovr_a), .busy(busy_a)
  );

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_b), .rd(rd_b),
    .rx_data(data_b), .rx_valid(valid_b), .framing_err(ferr_b),
    .parity_err(perr_b), .overrun_err(ovr_b), .busy(busy_b)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] m_data[2];
  logic m_valid[2], m_ovr[2], m_ferr[2], m_perr[2];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    s_tick = 0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1;
      @(negedge clk);
      s_tick = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_data[i] = 0; m_valid[i] = 0; m_ovr[i] = 0; m_ferr[i] = 0; m_perr[i] = 0;
    end
  endtask

  // One received frame: overrun if the previous one is still unread
  task automatic model_frame(input logic [7:0] d, input logic fe, input logic pe);
    int k = int'(sel);
    m_ovr[k]   = m_valid[k];
    m_valid[k] = 1;
    m_data[k]  = d;
    m_ferr[k]  = fe;
    m_perr[k]  = pe;
  endtask

  task automatic do_rd();
    int k = int'(sel);
    @(negedge clk); rd_req = 1;
    @(negedge clk); rd_req = 0;
    if (m_valid[k]) begin
      m_valid[k] = 0;
      m_ovr[k]   = 0;
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    line = b;
    repeat (63) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (sel) send_bit(pbit);
    send_bit(stop);
    model_frame(d, !stop, sel ? ((^d) ^ pbit) : 1'b0);
  endtask

  task automatic check_outputs(input string tag);
    int k = int'(sel);
    if (!sel) begin
      chk({tag, ".data"},  32'(data_a),  32'(m_data[k]));
      chk({tag, ".valid"}, 32'(valid_a), 32'(m_valid[k]));
      chk({tag, ".ferr"},  32'(ferr_a),  32'(m_ferr[k]));
      chk({tag, ".perr"},  32'(perr_a),  32'(m_perr[k]));
      chk({tag, ".ovr"},   32'(ovr_a),   32'(m_ovr[k]));
    end else begin
      chk({tag, ".data"},  32'(data_b),  32'(m_data[k]));
      chk({tag, ".valid"}, 32'(valid_b), 32'(m_valid[k]));
      chk({tag, ".ferr"},  32'(ferr_b),  32'(m_ferr[k]));
      chk({tag, ".perr"},  32'(perr_b),  32'(m_perr[k]));
      chk({tag, ".ovr"},   32'(ovr_b),   32'(m_ovr[k]));
    end
  endtask

  task automatic check_busy(input string tag, input logic exp);
    chk(tag, 32'(sel ? busy_b : busy_a), 32'(exp));
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  initial begin
    logic [7:0] d;
    logic bad_stop, pbit;
    line = 1; sel = 0; rd_req = 0; reset = 0;
    model_reset();
    pulse_reset();
    repeat (4) @(negedge clk);
    sel = 0; check_outputs("rst_a"); check_busy("rst_a.busy", 0);
    sel = 1; check_outputs("rst_b"); check_busy("rst_b.busy", 0);

    // 8N1 0x55
    sel = 0;
    send_frame(8'h55, 1'b0, 1'b1);
    send_bit(1'b1);
    check_outputs("f55");
    check_busy("f55.busy", 0);

    // start glitch of 4 ticks
    do_rd();
    @(negedge clk); line = 0;
    repeat (12) @(negedge clk);
    check_busy("glitch.busy_hi", 1);
    repeat (4) @(negedge clk);
    line = 1;
    repeat (40) @(negedge clk);
    check_busy("glitch.busy_lo", 0);
    check_outputs("glitch");

    // framing error then line held low
    send_frame(8'hA5, 1'b0, 1'b0);
    check_outputs("brk");
    check_busy("brk.busy", 1);
    do_rd();
    send_bit(1'b0);
    send_bit(1'b0);
    check_outputs("brk_low");
    check_busy("brk_low.busy", 1);
    send_bit(1'b1);
    check_busy("brk_rel.busy", 0);
    check_outputs("brk_rel");

    // even parity
    sel = 1;
    send_frame(8'h07, 1'b0, 1'b1);
    send_bit(1'b1);
    check_outputs("par_bad");
    do_rd();
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1);
    check_outputs("par_ok");
    do_rd();

    // overrun
    sel = 0;
    send_frame(8'h11, 1'b0, 1'b1);
    send_bit(1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    send_bit(1'b1);
    check_outputs("ovr");
    do_rd();
    check_outputs("ovr_rd");

    // reset during data bit 3
    d = 8'h0B;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    @(negedge clk); line = d[3];
    repeat (32) @(negedge clk);
    check_busy("midrst.busy_pre", 1);
    pulse_reset();
    line = 1;
    check_outputs("midrst");
    check_busy("midrst.busy", 0);
    send_bit(1'b1);
    send_frame(8'h3C, 1'b0, 1'b1);
    send_bit(1'b1);
    check_outputs("post_rst");

    // random frames on both instances
    for (int n = 0; n < 24; n++) begin
      sel      = n[0];
      d        = 8'($urandom);
      pbit     = 1'($urandom_range(0, 1));
      bad_stop = ($urandom_range(0, 5) == 0);
      send_frame(d, pbit, !bad_stop);
      send_bit(1'b1);
      check_outputs($sformatf("rnd%0d", n));
      check_busy($sformatf("rnd%0d.busy", n), 0);
      if ($urandom_range(0, 1) == 1) begin
        do_rd();
        check_outputs($sformatf("rnd%0d_rd", n));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
